operand_bit_serializer_axi: RTL
===============================

# operand_bit_serializer_axi

Upstream feeder for the bit-level half-adder stage in the 32x32 Vedic multiplier datapath. It accepts one WIDTH-bit operand on each of two AXI-Stream slave channels (A and B) and serializes them LSB-first into 2-bit tokens on two AXI-Stream master channels. Those master channels connect directly to the half adder's `s_a_*` and `s_b_*` inputs. The two master lanes advance in lockstep: bit i+1 is not offered on either lane until bit i has been accepted on both.

## Interface
- WIDTH, 32, operand width in bits; legal range 2..64
- clk  input  1  rising-edge clock; the only clock
- reset  input  1  synchronous, active-high reset
- s_a_tvalid  input  1  operand A valid
- s_a_tdata  input  WIDTH  operand A
- s_a_tready  output  1  operand A ready (registered)
- s_b_tvalid  input  1  operand B valid
- s_b_tdata  input  WIDTH  operand B
- s_b_tready  output  1  operand B ready (registered)
- m_a_tvalid  output  1  A token valid
- m_a_tdata  output  2  A token {last, bit}
- m_a_tready  input  1  A token accepted by downstream
- m_b_tvalid  output  1  B token valid
- m_b_tdata  output  2  B token {last, bit}
- m_b_tready  input  1  B token accepted by downstream

## Operation
- **State machine:** IDLE (collecting operands) and SEND (streaming bits).
- **IDLE:**
  - s_a_tready = !a_held; s_b_tready = !b_held.
  - A handshake on A captures s_a_tdata into a_shift and sets a_held; B behaves the same way independently.
  - A and B may arrive in either order or in the same cycle.
  - When both are held, by the edge that captures the second one, go to SEND with idx=0. Both readies drop to 0 on that same edge.
- **SEND:**
  - m_x_tvalid = !x_sent. m_x_tdata = {idx==WIDTH-1, x_shift[idx]}.
  - A handshake on lane x sets x_sent.
  - A bit is complete when both lanes have handshaken, whether in the same cycle or in different cycles. On completion: clear both sent flags and increment idx.
  - If the completed bit was WIDTH-1: clear a_held and b_held, go to IDLE, and assert both readies on the same edge.
- **Lane stability:** once m_x_tvalid is high, m_x_tvalid and m_x_tdata stay stable until m_x_tready is seen. A lane that has already been accepted stays low until the partner lane is accepted.
- **Slave data:** s_*_tdata is ignored unless the corresponding handshake occurs. No operand is dropped or duplicated.
- **Counter:** idx is $clog2(WIDTH) bits wide. It never wraps past WIDTH-1 and returns to 0 on entry to SEND.
- **Reset:**
  - On reset: state=IDLE, idx=0, all held/sent flags=0, s_a_tready=s_b_tready=0, m_a_tvalid=m_b_tvalid=0, m_a_tdata=m_b_tdata=2'b00.
  - The readies rise on the first clock edge with reset low.
  - Reset asserted mid-SEND abandons the operand pair; no partial tokens follow.

## Timing
- **Operand to first token:** the second operand captured at edge T puts m_*_tvalid high after edge T, so the first token is visible in cycle T+1.
- **Token rate:** with both m_*_tready held high, one bit per cycle on each lane. The last token is accepted at edge T+WIDTH, and s_*_tready is high in the following cycle.
- **Throughput:** WIDTH+1 cycles per operand pair at full rate.
- **Skewed acceptance:** the bit period stretches to the later of the two handshakes. The lane accepted first is idle, with tvalid=0, for the remaining cycles.
- **Output registers:** all outputs are registered. There is no combinational path from any input to any output.

## Structure
- **Shared package `serializer_pkg`:**
  - State encoding localparams: IDLE=1'b0, SEND=1'b1.
  - TOKEN_W=2.
  - Token field indices: TOK_BIT=0, TOK_LAST=1.
- **Sub-module `serializer_lane`:**
  - Instantiated twice, for A and B.
  - Contains the operand capture register, held flag, sent flag, slave-ready and master-valid/data registers.
  - Control inputs: capture_en, bit_done, idx.
  - Status outputs: held, sent.
- **Top level:** owns the FSM, idx, and the completion logic (both lanes sent).

## Test plan
Use WIDTH=4 unless stated otherwise.
- **Basic stream:** reset, then A=4'b1011 and B=4'b0110 in the same cycle, both m_tready=1.
  - A tokens: 01, 01, 00, 11. B tokens: 00, 01, 01, 10.
  - Readies return high one cycle after the fourth token.
- **Staggered operands:** A arrives at cycle 3, B at cycle 7.
  - s_a_tready is low during cycles 4–7.
  - No m_tvalid before cycle 8.
  - Token values are correct.
- **Lane skew:** m_a_tready=1 constantly, m_b_tready asserted only every 3rd cycle.
  - A holds bit i+1 until B accepts bit i.
  - m_a_tvalid=0 while waiting.
  - Data stable throughout; 12 cycles total for 4 bits.
- **Backpressure:** both m_tready=0 for 5 cycles with tvalid high.
  - m_a_tdata and m_b_tdata are unchanged.
  - idx does not advance.
- **Mid-stream reset:** assert reset during bit 2.
  - The next cycle shows all outputs at their reset values.
  - After release, a new pair A=4'hF, B=4'h0 streams correctly: A tokens 01, 01, 01, 11; B tokens 00, 00, 00, 10.
- **WIDTH=32 back-to-back:** 100 random pairs.
  - The scoreboard reassembles each operand bit-exactly.
  - The last flag appears on bit 31 only.

Source files
------------

// File: rtl/serializer_pkg.sv
// Shared encodings for the operand bit serializer: FSM states and the
// 2-bit {last, bit} token layout used on both master lanes.
package serializer_pkg;

  localparam logic IDLE = 1'b0;
  localparam logic SEND = 1'b1;

  localparam int TOKEN_W  = 2;
  localparam int TOK_BIT  = 0;
  localparam int TOK_LAST = 1;

  typedef enum logic {
    ST_IDLE = IDLE,
    ST_SEND = SEND
  } state_e;

endpackage

// File: rtl/serializer_lane.sv
// One operand lane: captures a WIDTH-bit operand from its slave channel and
// offers it bit by bit as registered {last, bit} tokens on its master channel.
module serializer_lane
  import serializer_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int IDX_W = $clog2(WIDTH)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               s_tvalid,
  input  logic [WIDTH-1:0]   s_tdata,
  output logic               s_tready,
  output logic               m_tvalid,
  output logic [TOKEN_W-1:0] m_tdata,
  input  logic               m_tready,
  input  logic               capture_en,
  input  logic               bit_done,
  input  logic               release_en,
  input  logic               send_next,
  input  logic [IDX_W-1:0]   idx,
  output logic               held,
  output logic               sent
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);

  logic [WIDTH-1:0]   shift_q, shift_d;
  logic               held_q, held_d;
  logic               sent_q, sent_d;
  logic               s_tready_q, s_tready_d;
  logic               m_tvalid_q, m_tvalid_d;
  logic [TOKEN_W-1:0] m_tdata_q, m_tdata_d;
  logic               s_fire, m_fire;

  // Status reflects this cycle's handshakes so the top can decide in one edge.
  assign s_fire = capture_en && s_tvalid && s_tready_q;
  assign m_fire = m_tvalid_q && m_tready;
  assign held   = held_q || s_fire;
  assign sent   = sent_q || m_fire;

  always_comb begin
    shift_d    = s_fire ? s_tdata : shift_q;
    held_d     = release_en ? 1'b0 : held;
    sent_d     = bit_done ? 1'b0 : sent;
    s_tready_d = !send_next && !held_d;
    m_tvalid_d = send_next && !sent_d;
    m_tdata_d  = '0;
    if (send_next) begin
      m_tdata_d[TOK_BIT]  = shift_d[idx];
      m_tdata_d[TOK_LAST] = (idx == LAST_IDX);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      shift_q    <= '0;
      held_q     <= 1'b0;
      sent_q     <= 1'b0;
      s_tready_q <= 1'b0;
      m_tvalid_q <= 1'b0;
      m_tdata_q  <= '0;
    end else begin
      shift_q    <= shift_d;
      held_q     <= held_d;
      sent_q     <= sent_d;
      s_tready_q <= s_tready_d;
      m_tvalid_q <= m_tvalid_d;
      m_tdata_q  <= m_tdata_d;
    end
  end

  assign s_tready = s_tready_q;
  assign m_tvalid = m_tvalid_q;
  assign m_tdata  = m_tdata_q;

endmodule

// File: rtl/operand_bit_serializer_axi.sv
// Serializes an A/B operand pair LSB-first into lockstep 2-bit token streams
// feeding the bit-level half-adder stage of the Vedic multiplier.
module operand_bit_serializer_axi
  import serializer_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               s_a_tvalid,
  input  logic [WIDTH-1:0]   s_a_tdata,
  output logic               s_a_tready,
  input  logic               s_b_tvalid,
  input  logic [WIDTH-1:0]   s_b_tdata,
  output logic               s_b_tready,
  output logic               m_a_tvalid,
  output logic [TOKEN_W-1:0] m_a_tdata,
  input  logic               m_a_tready,
  output logic               m_b_tvalid,
  output logic [TOKEN_W-1:0] m_b_tdata,
  input  logic               m_b_tready
);

  localparam int               IDX_W    = $clog2(WIDTH);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             capture_en, bit_done, last_done, send_next;
  logic             a_held, b_held, a_sent, b_sent;

  assign capture_en = (state_q == ST_IDLE);
  assign bit_done   = (state_q == ST_SEND) && a_sent && b_sent;
  assign last_done  = bit_done && (idx_q == LAST_IDX);
  assign send_next  = (state_d == ST_SEND);

  // A bit period ends only once both lanes have handshaken, in any order.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      ST_IDLE: begin
        if (a_held && b_held) begin
          state_d = ST_SEND;
          idx_d   = '0;
        end
      end
      ST_SEND: begin
        if (last_done) begin
          state_d = ST_IDLE;
          idx_d   = '0;
        end else if (bit_done) begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        idx_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  serializer_lane #(.WIDTH(WIDTH), .IDX_W(IDX_W)) u_lane_a (
    .clk        (clk),
    .reset      (reset),
    .s_tvalid   (s_a_tvalid),
    .s_tdata    (s_a_tdata),
    .s_tready   (s_a_tready),
    .m_tvalid   (m_a_tvalid),
    .m_tdata    (m_a_tdata),
    .m_tready   (m_a_tready),
    .capture_en (capture_en),
    .bit_done   (bit_done),
    .release_en (last_done),
    .send_next  (send_next),
    .idx        (idx_d),
    .held       (a_held),
    .sent       (a_sent)
  );

  serializer_lane #(.WIDTH(WIDTH), .IDX_W(IDX_W)) u_lane_b (
    .clk        (clk),
    .reset      (reset),
    .s_tvalid   (s_b_tvalid),
    .s_tdata    (s_b_tdata),
    .s_tready   (s_b_tready),
    .m_tvalid   (m_b_tvalid),
    .m_tdata    (m_b_tdata),
    .m_tready   (m_b_tready),
    .capture_en (capture_en),
    .bit_done   (bit_done),
    .release_en (last_done),
    .send_next  (send_next),
    .idx        (idx_d),
    .held       (b_held),
    .sent       (b_sent)
  );

endmodule
